decrypter: RTL and testbench
============================

# decrypter

Streaming 16-bit word decrypter, the receive-side counterpart of the encrypter. It accepts cipher words and per-word rotation offsets over a four-phase request/ready input handshake and inverts the encryption transform: `plain = rotr(cipher, rot_offset) ^ key`. It delivers plaintext over a four-phase request/ready output handshake. The key is programmed through the data port under `prog`.

## Interface
- `DATA_WIDTH`, default `ENCRYPTER_WIDTH` (16): cipher/plain word width.
- `KEY_WIDTH`, default `KEY_WIDTH` (16): key width; must equal `DATA_WIDTH`.
- `ROT_WIDTH`, default `KEY_ROTATION_WIDTH` (4): rotation offset width.
- `clk`  in  1: the single clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `dataIn`  in  DATA_WIDTH: cipher word, or key value when `prog` is high.
- `rot_offset`  in  ROT_WIDTH: right-rotation amount for the current word.
- `rdyIn`  in  1: source has valid `dataIn`/`rot_offset`.
- `prog`  in  1: key load strobe.
- `rdyOut`  in  1: sink has taken `dataOut`.
- `dataOut`  out  DATA_WIDTH: plaintext word, registered.
- `reqIn`  out  1: decrypter requests an input word.
- `reqOut`  out  1: `dataOut` is valid.
- `state`  out  3: FSM state, for debug.
- `key`  out  KEY_WIDTH: current key register.

## Operation
- State encodings: IDLE=0, REQ_IN=1, IN_REL=2, DECRYPT=3, REQ_OUT=4, OUT_REL=5. Codes 6 and 7 go to IDLE.
- IDLE: `reqIn`=0 and `reqOut`=0. If `prog`=1: `key` <= `dataIn`, next state REQ_IN. Otherwise stay in IDLE.
- REQ_IN: `reqIn`=1.
  - If `rdyIn`=1: capture `dataIn` and `rot_offset` into internal registers; next state IN_REL.
  - Else if `prog`=1: re-key (`key` <= `dataIn`); stay in REQ_IN.
- IN_REL: `reqIn`=0. Wait for `rdyIn`=0, then go to DECRYPT.
- DECRYPT: `dataOut` <= rotr(captured word, captured offset) ^ `key`; next state REQ_OUT.
- REQ_OUT: `reqOut`=1 and `dataOut` is held. When `rdyOut`=1, go to OUT_REL.
- OUT_REL: `reqOut`=0. When `rdyOut`=0, go to REQ_IN (apply the key roll if it is compiled in).
- Arithmetic rules:
  - Rotation is modulo DATA_WIDTH; offset 0 is the identity.
  - With DATA_WIDTH=16 every 4-bit offset is valid and no wrap is needed.
  - XOR is bitwise at full width; nothing is truncated.
- `prog` is ignored in IN_REL, DECRYPT, REQ_OUT and OUT_REL. `dataIn` changes outside REQ_IN are ignored.

## Timing
- Reset values: `dataOut`=0, `reqIn`=0, `reqOut`=0, `state`=IDLE (0), `key`=0. Internal capture registers are also 0.
- Reset has priority over every transition. Reset mid-transfer (including while in REQ_OUT) aborts the word, drops both requests the next edge, and clears the key.
- All outputs are registered and change only on the `clk` rising edge.
- `reqIn` rises the cycle after entering REQ_IN. It falls the edge after `rdyIn`=1 is sampled.
- Minimum latency, from the `rdyIn` sample edge to `reqOut` high: 3 cycles, provided `rdyIn` falls immediately.
- When `rdyIn` and `prog` are both high in REQ_IN, data capture wins and the key is unchanged.
- If `rdyIn` is still high on return to REQ_IN, it is accepted as a new word. The source must obey four-phase ordering.
- `dataOut` is stable from REQ_OUT entry until the next DECRYPT.

## Configuration
- `DECRYPTER_KEY_ROLL_EN`
  - Defined: on each OUT_REL to REQ_IN transition, `key` <= rotl(`key`, 1). This matches an encrypter built with key rolling.
  - Undefined: the key stays static until reloaded by `prog`.

## Test plan
- Reset for 1 cycle -> all outputs 0, `state`=0. Hold `prog`=0 -> stays in IDLE with `reqIn`=0.
- `prog`=1 with `dataIn`=16'hCCE3 -> `key`=16'hCCE3 and `reqIn`=1. Then supply cipher 16'hF0F0 with offset 7 and complete both handshakes -> `dataOut`=16'h2D02 with `reqOut`=1 three cycles after `rdyIn` is sampled.
- Key 16'hCCE3, cipher 16'hF0F0, offset 0 -> `dataOut`=16'h3C13.
- Key 0, cipher 16'h1234, offset 8 -> `dataOut`=16'h3412. Hold `rdyOut` low for 10 cycles -> `reqOut` and `dataOut` stay constant.
- With `DECRYPTER_KEY_ROLL_EN` and key 16'hCCE3 -> after the first word, `key`=16'h99C7. Without the macro -> `key` stays 16'hCCE3.
- Assert `reset` while in REQ_OUT -> next edge `reqOut`=0, `key`=0, `state`=0. `rdyIn` and `prog` held high together in REQ_IN -> word captured and key unchanged.

Source files
------------

// File: rtl/decrypter.sv
// Streaming word decrypter: plain = rotr(cipher, offset) ^ key, with four-phase handshakes on both sides.
// Optional key rolling after every delivered word is enabled by defining DECRYPTER_KEY_ROLL_EN.
module decrypter #(
    parameter int DATA_WIDTH = 16,
    parameter int KEY_WIDTH  = 16,
    parameter int ROT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic [ROT_WIDTH-1:0]  rot_offset,
    input  logic                  rdyIn,
    input  logic                  prog,
    input  logic                  rdyOut,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  reqIn,
    output logic                  reqOut,
    output logic [2:0]            state,
    output logic [KEY_WIDTH-1:0]  key
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_IN  = 3'd1,
        IN_REL  = 3'd2,
        DECRYPT = 3'd3,
        REQ_OUT = 3'd4,
        OUT_REL = 3'd5
    } state_t;

    state_t                  state_reg;
    logic [DATA_WIDTH-1:0]   cap_word_reg;
    logic [ROT_WIDTH-1:0]    cap_rot_reg;
    logic [DATA_WIDTH-1:0]   data_out_reg;
    logic [KEY_WIDTH-1:0]    key_reg;
    logic                    req_in_reg;
    logic                    req_out_reg;
    logic [DATA_WIDTH-1:0]   rot_word;

    // Logarithmic right rotator: stage gi rotates by 2**gi mod DATA_WIDTH, so the
    // composed rotation is already reduced modulo the word width.
    for (genvar gi = 0; gi < ROT_WIDTH; gi++) begin : g_stage
        localparam int SH = (2 ** gi) % DATA_WIDTH;
        logic [DATA_WIDTH-1:0] din;
        logic [DATA_WIDTH-1:0] rotated;
        logic [DATA_WIDTH-1:0] dout;

        if (gi == 0) begin : g_first
            assign din = cap_word_reg;
        end else begin : g_chain
            assign din = g_stage[gi-1].dout;
        end

        if (SH == 0) begin : g_identity
            assign rotated = din;
        end else begin : g_rotate
            assign rotated = {din[SH-1:0], din[DATA_WIDTH-1:SH]};
        end

        assign dout = cap_rot_reg[gi] ? rotated : din;
    end

    assign rot_word = g_stage[ROT_WIDTH-1].dout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cap_word_reg <= '0;
            cap_rot_reg  <= '0;
            data_out_reg <= '0;
            key_reg      <= '0;
            req_in_reg   <= 1'b0;
            req_out_reg  <= 1'b0;
        end else begin
            // Requests follow the state with one cycle of lag.
            req_in_reg  <= (state_reg == REQ_IN);
            req_out_reg <= (state_reg == REQ_OUT);

            case (state_reg)
                IDLE: begin
                    if (prog) begin
                        key_reg   <= dataIn;
                        state_reg <= REQ_IN;
                    end
                end
                REQ_IN: begin
                    if (rdyIn) begin
                        cap_word_reg <= dataIn;
                        cap_rot_reg  <= rot_offset;
                        state_reg    <= IN_REL;
                    end else if (prog) begin
                        key_reg <= dataIn;
                    end
                end
                IN_REL: begin
                    if (!rdyIn) begin
                        state_reg <= DECRYPT;
                    end
                end
                DECRYPT: begin
                    data_out_reg <= rot_word ^ key_reg;
                    state_reg    <= REQ_OUT;
                end
                REQ_OUT: begin
                    if (rdyOut) begin
                        state_reg <= OUT_REL;
                    end
                end
                OUT_REL: begin
                    if (!rdyOut) begin
                        state_reg <= REQ_IN;
`ifdef DECRYPTER_KEY_ROLL_EN
                        key_reg <= {key_reg[KEY_WIDTH-2:0], key_reg[KEY_WIDTH-1]};
`endif
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign dataOut = data_out_reg;
    assign reqIn   = req_in_reg;
    assign reqOut  = req_out_reg;
    assign state   = state_reg;
    assign key     = key_reg;

endmodule

// File: tb/tb_decrypter.sv
// Self-checking bench for decrypter: directed vectors, handshake timing, reset and randomized words.
module tb_decrypter;

    logic        clk;
    logic        reset;
    logic [15:0] dataIn;
    logic [3:0]  rot_offset;
    logic        rdyIn;
    logic        prog;
    logic        rdyOut;
    logic [15:0] dataOut;
    logic        reqIn;
    logic        reqOut;
    logic [2:0]  state;
    logic [15:0] key;

    int          checks;
    int          errors;
    logic [15:0] exp_key;

`ifdef DECRYPTER_KEY_ROLL_EN
    localparam logic [15:0] KEY_AFTER_FIRST = 16'h99C7;
`else
    localparam logic [15:0] KEY_AFTER_FIRST = 16'hCCE3;
`endif

    decrypter #(.DATA_WIDTH(16), .KEY_WIDTH(16), .ROT_WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .dataIn     (dataIn),
        .rot_offset (rot_offset),
        .rdyIn      (rdyIn),
        .prog       (prog),
        .rdyOut     (rdyOut),
        .dataOut    (dataOut),
        .reqIn      (reqIn),
        .reqOut     (reqOut),
        .state      (state),
        .key        (key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain bit i comes from cipher bit (i + offset) mod 16.
    function automatic logic [15:0] ref_decrypt(input logic [15:0] c, input int off, input logic [15:0] k);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = c[(i + off) % 16] ^ k[i];
        return r;
    endfunction

    function automatic logic [15:0] ref_next_key(input logic [15:0] k);
`ifdef DECRYPTER_KEY_ROLL_EN
        return 16'((32'(k) * 2) % 65536 + 32'(k) / 32768);
`else
        return k;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req_in(output int n);
        n = 0;
        while (reqIn !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic rekey(input logic [15:0] k);
        prog   = 1'b1;
        dataIn = k;
        tick();
        prog    = 1'b0;
        dataIn  = 16'($urandom);
        exp_key = k;
    endtask

    // Returns the number of edges from the rdyIn sample edge to reqOut high (99 on timeout).
    task automatic push_word(input logic [15:0] c, input logic [3:0] off, output int lat);
        int n;
        wait_req_in(n);
        if (n >= 50) begin
            lat = 99;
            return;
        end
        dataIn     = c;
        rot_offset = off;
        rdyIn      = 1'b1;
        tick();
        rdyIn  = 1'b0;
        dataIn = 16'($urandom);
        n = 0;
        while (reqOut !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        lat = (n >= 50) ? 99 : n;
    endtask

    task automatic pop_word(output bit ok);
        int n;
        rdyOut = 1'b1;
        n = 0;
        while (reqOut !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        rdyOut = 1'b0;
        ok = (n < 50);
        exp_key = ref_next_key(exp_key);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (dataOut !== 16'h0) begin errors++; $display("FAIL reset_dataOut: got %h expected %h", dataOut, 16'h0); end
        checks++; if (reqIn !== 1'b0) begin errors++; $display("FAIL reset_reqIn: got %b expected 0", reqIn); end
        checks++; if (reqOut !== 1'b0) begin errors++; $display("FAIL reset_reqOut: got %b expected 0", reqOut); end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (key !== 16'h0) begin errors++; $display("FAIL reset_key: got %h expected %h", key, 16'h0); end
        reset = 1'b0;
        rdyIn = 1'b1;
        repeat (3) tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL idle_hold_state: got %0d expected 0", state); end
        checks++; if (reqIn !== 1'b0) begin errors++; $display("FAIL idle_hold_reqIn: got %b expected 0", reqIn); end
        rdyIn = 1'b0;
        exp_key = 16'h0;
    endtask

    task automatic test_key_load();
        prog   = 1'b1;
        dataIn = 16'hCCE3;
        tick();
        prog   = 1'b0;
        dataIn = 16'h5A5A;
        exp_key = 16'hCCE3;
        checks++; if (key !== 16'hCCE3) begin errors++; $display("FAIL key_load: got %h expected %h", key, 16'hCCE3); end
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL key_load_state: got %0d expected 1", state); end
        tick();
        checks++; if (reqIn !== 1'b1) begin errors++; $display("FAIL key_load_reqIn: got %b expected 1", reqIn); end
    endtask

    task automatic test_vectors();
        int lat;
        int n;
        bit ok;
        push_word(16'hF0F0, 4'd7, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL vec1_latency: got %0d expected 3", lat); end
        checks++; if (dataOut !== 16'h2D02) begin errors++; $display("FAIL vec1_data: got %h expected %h", dataOut, 16'h2D02); end
        pop_word(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL vec1_release: got %b expected 1", ok); end
        wait_req_in(n);
        checks++; if (key !== KEY_AFTER_FIRST) begin errors++; $display("FAIL vec1_key_after: got %h expected %h", key, KEY_AFTER_FIRST); end

        rekey(16'hCCE3);
        checks++; if (key !== 16'hCCE3) begin errors++; $display("FAIL rekey_req_in: got %h expected %h", key, 16'hCCE3); end
        push_word(16'hF0F0, 4'd0, lat);
        checks++; if (dataOut !== 16'h3C13) begin errors++; $display("FAIL vec2_data: got %h expected %h", dataOut, 16'h3C13); end
        pop_word(ok);
        wait_req_in(n);

        rekey(16'h0000);
        push_word(16'h1234, 4'd8, lat);
        checks++; if (dataOut !== 16'h3412) begin errors++; $display("FAIL vec3_data: got %h expected %h", dataOut, 16'h3412); end
        // Sink stalls; prog and dataIn activity must not disturb the held word or the key.
        for (int i = 0; i < 10; i++) begin
            prog   = 1'(i % 2);
            dataIn = 16'($urandom);
            tick();
            checks++; if (reqOut !== 1'b1) begin errors++; $display("FAIL hold_reqOut[%0d]: got %b expected 1", i, reqOut); end
            checks++; if (dataOut !== 16'h3412) begin errors++; $display("FAIL hold_dataOut[%0d]: got %h expected %h", i, dataOut, 16'h3412); end
        end
        prog = 1'b0;
        checks++; if (key !== 16'h0000) begin errors++; $display("FAIL hold_key: got %h expected %h", key, 16'h0000); end
        pop_word(ok);
        wait_req_in(n);
    endtask

    task automatic test_prog_priority();
        int n;
        logic [15:0] c;
        logic [3:0]  off;
        logic [15:0] exp;
        wait_req_in(n);
        c          = 16'($urandom);
        off        = 4'($urandom);
        exp        = ref_decrypt(c, int'(off), exp_key);
        dataIn     = c;
        rot_offset = off;
        rdyIn      = 1'b1;
        prog       = 1'b1;
        tick();
        rdyIn = 1'b0;
        prog  = 1'b0;
        checks++; if (key !== exp_key) begin errors++; $display("FAIL prio_key: got %h expected %h", key, exp_key); end
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL prio_state: got %0d expected 2", state); end
        n = 0;
        while (reqOut !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++; if (dataOut !== exp) begin errors++; $display("FAIL prio_data: got %h expected %h", dataOut, exp); end
        begin
            bit ok;
            pop_word(ok);
        end
        wait_req_in(n);
    endtask

    task automatic test_random();
        int lat;
        int n;
        int h;
        bit ok;
        logic [15:0] c;
        logic [15:0] k;
        logic [3:0]  off;
        logic [15:0] exp;
        for (int it = 0; it < 24; it++) begin
            wait_req_in(n);
            if ($urandom_range(0, 2) == 0) begin
                k = 16'($urandom);
                rekey(k);
                checks++; if (key !== k) begin errors++; $display("FAIL rand_rekey[%0d]: got %h expected %h", it, key, k); end
            end
            c   = 16'($urandom);
            off = 4'($urandom);
            exp = ref_decrypt(c, int'(off), exp_key);
            push_word(c, off, lat);
            checks++; if (lat !== 3) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected 3", it, lat); end
            checks++; if (dataOut !== exp) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h (c=%h off=%0d key=%h)", it, dataOut, exp, c, off, exp_key); end
            h = int'($urandom_range(0, 3));
            repeat (h) begin
                tick();
                checks++; if (dataOut !== exp) begin errors++; $display("FAIL rand_stable[%0d]: got %h expected %h", it, dataOut, exp); end
            end
            pop_word(ok);
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rand_release[%0d]: got %b expected 1", it, ok); end
            wait_req_in(n);
            checks++; if (key !== exp_key) begin errors++; $display("FAIL rand_key[%0d]: got %h expected %h", it, key, exp_key); end
        end
    endtask

    task automatic test_reset_in_req_out();
        int lat;
        push_word(16'hBEEF, 4'd3, lat);
        checks++; if (reqOut !== 1'b1) begin errors++; $display("FAIL rst_pre_reqOut: got %b expected 1", reqOut); end
        reset = 1'b1;
        tick();
        checks++; if (reqOut !== 1'b0) begin errors++; $display("FAIL rst_reqOut: got %b expected 0", reqOut); end
        checks++; if (key !== 16'h0) begin errors++; $display("FAIL rst_key: got %h expected %h", key, 16'h0); end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", state); end
        checks++; if (dataOut !== 16'h0) begin errors++; $display("FAIL rst_dataOut: got %h expected %h", dataOut, 16'h0); end
        reset   = 1'b0;
        exp_key = 16'h0;
        tick();
        checks++; if (reqIn !== 1'b0) begin errors++; $display("FAIL rst_idle_reqIn: got %b expected 0", reqIn); end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        prog       = 1'b0;
        rdyIn      = 1'b0;
        rdyOut     = 1'b0;
        dataIn     = 16'h0;
        rot_offset = 4'h0;
        exp_key    = 16'h0;
        test_reset();
        test_key_load();
        test_vectors();
        test_prog_priority();
        test_random();
        test_reset_in_req_out();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected completion within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
